// File: rtl/axilite_lb_pkg.sv
// rtl/axilite_lb_pkg.sv - response codes and FSM state types shared by the AXI-Lite to LB bridge
package axilite_lb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_LB, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_LB, R_RESP} rd_state_t;

endpackage

// File: rtl/axilite_lb_timer.sv
// rtl/axilite_lb_timer.sv - clearable saturating wait counter with expiry flag
// Instantiated by axilite_lb_bridge only when AXILITE_LB_TIMEOUT_EN is defined.
module axilite_lb_timer #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] count;

  // Counts cycles spent in a wait state; holds once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/axilite_lb_bridge.sv
// rtl/axilite_lb_bridge.sv - AXI4-Lite responder converting each transaction into a single-beat LB access
// Optional LB wait timeout with SLVERR response is compiled in by AXILITE_LB_TIMEOUT_EN.
module axilite_lb_bridge
  import axilite_lb_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int STRB_W         = DATA_W / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [2:0]        AWPROT,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic [DATA_W-1:0] WDATA,
  input  logic [STRB_W-1:0] WSTRB,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [2:0]        ARPROT,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [ADDR_W-1:0] lb_waddr,
  output logic [DATA_W-1:0] lb_wdata,
  output logic [STRB_W-1:0] lb_wstrb,
  output logic              lb_wen,
  input  logic              lb_wready,
  output logic [ADDR_W-1:0] lb_raddr,
  output logic              lb_ren,
  input  logic [DATA_W-1:0] lb_rdata,
  input  logic              lb_rvalid
);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;
  logic      aw_held, w_held, aw_held_d, w_held_d;
  logic      aw_fire, w_fire, ar_fire, b_fire, r_fire;
  logic      wr_expired, rd_expired;
  logic      awready_d, wready_d, lb_wen_d, bvalid_d;
  logic      arready_d, lb_ren_d, rvalid_d;
  logic      unused_prot;

  assign unused_prot = ^{AWPROT, ARPROT};

  assign aw_fire = AWVALID & AWREADY;
  assign w_fire  = WVALID & WREADY;
  assign ar_fire = ARVALID & ARREADY;
  assign b_fire  = BVALID & BREADY;
  assign r_fire  = RVALID & RREADY;

`ifdef AXILITE_LB_TIMEOUT_EN
  axilite_lb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_wr_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wr_state != W_LB),
    .expired (wr_expired)
  );

  axilite_lb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_rd_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (rd_state != R_LB),
    .expired (rd_expired)
  );
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign wr_expired = 1'b0;
  assign rd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
      aw_held  <= aw_held_d;
      w_held   <= w_held_d;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if ((aw_held | aw_fire) && (w_held | w_fire)) wr_next = W_LB;
      W_LB:    if (lb_wready || wr_expired) wr_next = W_RESP;
      W_RESP:  if (b_fire) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase

    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_fire) rd_next = R_LB;
      R_LB:    if (lb_rvalid || rd_expired) rd_next = R_RESP;
      R_RESP:  if (r_fire) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  // Next values of the registered outputs; held flags only live while waiting in W_IDLE.
  always_comb begin
    aw_held_d = (wr_state == W_IDLE) && (wr_next == W_IDLE) && (aw_held | aw_fire);
    w_held_d  = (wr_state == W_IDLE) && (wr_next == W_IDLE) && (w_held | w_fire);
    awready_d = (wr_next == W_IDLE) && !aw_held_d;
    wready_d  = (wr_next == W_IDLE) && !w_held_d;
    lb_wen_d  = (wr_next == W_LB);
    bvalid_d  = (wr_next == W_RESP);
    arready_d = (rd_next == R_IDLE);
    lb_ren_d  = (rd_next == R_LB);
    rvalid_d  = (rd_next == R_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RRESP    <= RESP_OKAY;
      RDATA    <= '0;
      lb_wen   <= 1'b0;
      lb_waddr <= '0;
      lb_wdata <= '0;
      lb_wstrb <= '0;
      lb_ren   <= 1'b0;
      lb_raddr <= '0;
    end else begin
      AWREADY <= awready_d;
      WREADY  <= wready_d;
      BVALID  <= bvalid_d;
      ARREADY <= arready_d;
      RVALID  <= rvalid_d;
      lb_wen  <= lb_wen_d;
      lb_ren  <= lb_ren_d;
      if (aw_fire) lb_waddr <= AWADDR;
      if (w_fire) begin
        lb_wdata <= WDATA;
        lb_wstrb <= WSTRB;
      end
      if (ar_fire) lb_raddr <= ARADDR;
      // A ready arriving on the expiry cycle takes priority over the timeout.
      if (wr_state == W_LB && wr_next == W_RESP) BRESP <= lb_wready ? RESP_OKAY : RESP_SLVERR;
      if (rd_state == R_LB && rd_next == R_RESP) begin
        RDATA <= lb_rvalid ? lb_rdata : '0;
        RRESP <= lb_rvalid ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axilite_lb_bridge.sv
// tb/tb_axilite_lb_bridge.sv - self-checking bench for axilite_lb_bridge against a word-memory model
// Timeout cases run when AXILITE_LB_TIMEOUT_EN is defined (TIMEOUT_CYCLES=8).
module tb_axilite_lb_bridge;

`ifdef AXILITE_LB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] AWADDR, ARADDR, lb_waddr, lb_raddr;
  logic [2:0]  AWPROT, ARPROT;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA, lb_wdata, lb_rdata;
  logic [3:0]  WSTRB, lb_wstrb;
  logic [1:0]  BRESP, RRESP;
  logic        lb_wen, lb_wready, lb_ren, lb_rvalid;

  axilite_lb_bridge #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .lb_wstrb(lb_wstrb), .lb_wen(lb_wen),
    .lb_wready(lb_wready), .lb_raddr(lb_raddr), .lb_ren(lb_ren), .lb_rdata(lb_rdata),
    .lb_rvalid(lb_rvalid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference memory (what AXI writes should produce) and the LB slave's own storage.
  logic [31:0] refmem [int];
  logic [31:0] lbmem [int];

  function automatic logic [31:0] refword(input logic [15:0] a);
    return refmem.exists(int'(a)) ? refmem[int'(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] lbword(input logic [15:0] a);
    return lbmem.exists(int'(a)) ? lbmem[int'(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // LB slave: answers after wlat/rlat extra cycles, or never when lb_dead is set.
  int          wlat = 0, rlat = 0;
  bit          lb_dead = 1'b0;
  int          wrun = 0, rrun = 0, wen_len = 0, ren_len = 0;
  int unsigned wen_rise = 0, ren_rise = 0;
  int          nwrites = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wstrb = '0;

  initial begin
    lb_wready = 1'b0;
    lb_rvalid = 1'b0;
    lb_rdata  = '0;
    forever begin
      @(negedge clk);
      if (lb_wen) begin
        if (wrun == 0) wen_rise = cyc;
        lb_wready = !lb_dead && (wrun == wlat);
        if (lb_wready) begin
          lbmem[int'(lb_waddr)] = merge(lbword(lb_waddr), lb_wdata, lb_wstrb);
          nwrites++;
          last_waddr = lb_waddr;
          last_wdata = lb_wdata;
          last_wstrb = lb_wstrb;
        end
        wrun++;
      end else begin
        lb_wready = 1'b0;
        if (wrun != 0) begin
          wen_len = wrun;
          wrun = 0;
        end
      end
      if (lb_ren) begin
        if (rrun == 0) ren_rise = cyc;
        lb_rvalid = !lb_dead && (rrun == rlat);
        lb_rdata  = lb_rvalid ? lbword(lb_raddr) : $urandom();
        rrun++;
      end else begin
        lb_rvalid = 1'b0;
        if (rrun != 0) begin
          ren_len = rrun;
          rrun = 0;
        end
      end
    end
  end

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_at, input int w_at, input int bdly,
                           output logic [1:0] resp, output int unsigned hs, output int unsigned bc,
                           output int bad);
    bit aw_done = 1'b0, w_done = 1'b0, aw_f, w_f;
    int n = 0;
    bad = 0; hs = 0; bc = 0;
    AWADDR = a; WDATA = d; WSTRB = s; AWPROT = 3'($urandom());
    while (!(aw_done && w_done) && n < 50) begin
      if (aw_done && AWREADY) bad++;
      if (w_done && WREADY) bad++;
      AWVALID = !aw_done && n >= aw_at;
      WVALID  = !w_done && n >= w_at;
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      if (aw_f || w_f) hs = cyc;
      @(negedge clk);
      n++;
      aw_done |= aw_f;
      w_done  |= w_f;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    chk("aw_w_accepted", {aw_done, w_done}, 2'b11);
    n = 0;
    while (!BVALID && n < TO + 50) begin
      bad += int'(AWREADY | WREADY);
      @(negedge clk);
      n++;
    end
    chk("bvalid_seen", BVALID, 1'b1);
    bc = cyc;
    resp = BRESP;
    repeat (bdly) begin
      if (!BVALID || BRESP !== resp || AWREADY || WREADY) bad++;
      @(negedge clk);
    end
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("ready_after_b", {AWREADY, WREADY, BVALID}, 3'b110);
  endtask

  task automatic axi_read(input logic [15:0] a, input int rdly,
                          output logic [31:0] data, output logic [1:0] resp,
                          output int unsigned hs, output int unsigned rc, output int bad);
    int n = 0;
    bad = 0; rc = 0;
    ARADDR = a; ARPROT = 3'($urandom()); ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("arready_seen", ARREADY, 1'b1);
    hs = cyc;
    @(negedge clk);
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < TO + 50) begin
      bad += int'(ARREADY);
      @(negedge clk);
      n++;
    end
    chk("rvalid_seen", RVALID, 1'b1);
    rc = cyc;
    data = RDATA;
    resp = RRESP;
    repeat (rdly) begin
      if (!RVALID || RDATA !== data || RRESP !== resp || ARREADY) bad++;
      @(negedge clk);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    chk("arready_after_r", {ARREADY, RVALID}, 2'b10);
  endtask

  task automatic wr_txn(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_at, input int w_at, input int wl, input int bdly);
    logic [1:0]  resp;
    logic [31:0] exp_word;
    int unsigned hs, bc;
    int          bad, n0;
    exp_word = merge(refword(a), d, s);
    wlat = wl;
    n0 = nwrites;
    axi_write(a, d, s, aw_at, w_at, bdly, resp, hs, bc, bad);
    chk("wr_count", nwrites - n0, 1);
    chk("wr_lb_addr", last_waddr, a);
    chk("wr_lb_data", last_wdata, d);
    chk("wr_lb_strb", last_wstrb, s);
    chk("wr_bresp", resp, 2'b00);
    chk("wr_wen_cycles", wen_len, wl + 1);
    chk("wr_b_latency", bc - hs, wl + 2);
    chk("wr_ready_low", bad, 0);
    refmem[int'(a)] = exp_word;
    chk("wr_lb_mem", lbword(a), exp_word);
  endtask

  task automatic rd_txn(input logic [15:0] a, input int rl, input int rdly, output logic [31:0] data);
    logic [1:0]  resp;
    logic [31:0] exp_word;
    int unsigned hs, rc;
    int          bad;
    exp_word = refword(a);
    rlat = rl;
    axi_read(a, rdly, data, resp, hs, rc, bad);
    chk("rd_data", data, exp_word);
    chk("rd_rresp", resp, 2'b00);
    chk("rd_ren_cycles", ren_len, rl + 1);
    chk("rd_r_latency", rc - hs, rl + 2);
    chk("rd_hold", bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, d;
    logic [15:0] a;
    logic [1:0]  rsp;
    int unsigned hs, hc;
    int          bad, n0;

    rst = 1'b1;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, lb_wen, lb_ren, BRESP, RRESP}, 13'h0);
    chk("reset_bus", {RDATA, lb_waddr, lb_wdata, lb_wstrb, lb_raddr}, 100'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {AWREADY, WREADY, ARREADY}, 3'b111);

    wr_txn(16'h0010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
    chk("w1_data_const", last_wdata, 32'hDEADBEEF);

    wr_txn(16'h0014, $urandom(), 4'h3, 3, 0, 0, 1);
    chk("w2_strb_const", lb_wstrb, 4'h3);

    wr_txn(16'h0004, 32'h12345678, 4'hF, 0, 2, 1, 0);
    rd_txn(16'h0004, 5, 4, rd);
    chk("r1_data_const", rd, 32'h12345678);

    fork
      wr_txn(16'h0008, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0);
      rd_txn(16'h000C, 0, 0, rd);
    join
    chk("concurrent_lb_start", {wen_rise}, {ren_rise});
    rd_txn(16'h0008, 0, 0, rd);

    wr_txn(16'h0020, 32'h0BADF00D, 4'hF, 0, 0, TO - 1, 0);
    rd_txn(16'h0020, TO - 1, 0, rd);

`ifdef AXILITE_LB_TIMEOUT_EN
    lb_dead = 1'b1;
    axi_read(16'h0004, 1, rd, rsp, hs, hc, bad);
    chk("to_rresp", rsp, 2'b10);
    chk("to_rdata", rd, 32'h0);
    chk("to_ren_cycles", ren_len, 8);
    chk("to_r_latency", hc - hs, 9);
    n0 = nwrites;
    axi_write(16'h0030, 32'h55AA55AA, 4'hF, 0, 0, 0, rsp, hs, hc, bad);
    chk("to_bresp", rsp, 2'b10);
    chk("to_wen_cycles", wen_len, 8);
    chk("to_no_lb_write", nwrites - n0, 0);
    lb_dead = 1'b0;
`endif

    lb_dead = 1'b1;
    AWADDR = 16'h0024; WDATA = 32'hFFFF0000; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge clk);
    chk("wen_before_rst", lb_wen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, lb_wen, lb_ren, BRESP}, 9'h0);
    chk("rst_abort_bus", {lb_waddr, lb_wdata, lb_wstrb}, 52'h0);
    rst = 1'b0;
    lb_dead = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {AWREADY, WREADY, ARREADY}, 3'b111);
    wr_txn(16'h0024, 32'h13579BDF, 4'hF, 0, 0, 0, 0);
    rd_txn(16'h0024, 0, 0, rd);

    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom_range(0, 31));
      d = $urandom();
      case ($urandom_range(0, 2))
        0: wr_txn(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
                  $urandom_range(0, 3), $urandom_range(0, 2));
        1: rd_txn(a, $urandom_range(0, 3), $urandom_range(0, 2), rd);
        default: fork
          wr_txn(a, d, 4'($urandom_range(0, 15)), 0, $urandom_range(0, 1), $urandom_range(0, 3), 0);
          rd_txn(a ^ 16'h0040, $urandom_range(0, 3), $urandom_range(0, 2), rd);
        join
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
